clk_edge_monitor: RTL and testbench

//   Receive side of our slow divided-clock scheme: samples a slow toggling signal
//   (e.g. a divider output at clk_in/2/(C0+1)) in the clk_in domain.

---
 rtl/clk_edge_monitor_if.sv | 33 +++
 rtl/clk_edge_monitor.sv | 139 +++++++++++++
 tb/tb_clk_edge_monitor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clk_edge_monitor_if.sv
// Signal bundle between the slow toggling source and the edge monitor:
// the toggling input plus the pulse, measurement and health outputs.
interface clk_edge_monitor_if #(
    parameter int CW = 26
);
    logic          sig_in;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] half_cnt;
    logic          half_valid;
    logic          locked;
    logic          lost;

    modport master (
        output sig_in,
        input  rise_pulse,
        input  fall_pulse,
        input  half_cnt,
        input  half_valid,
        input  locked,
        input  lost
    );

    modport slave (
        input  sig_in,
        output rise_pulse,
        output fall_pulse,
        output half_cnt,
        output half_valid,
        output locked,
        output lost
    );
endinterface

// File: rtl/clk_edge_monitor.sv
// Synchronises a slow toggling signal into clk_in, emits edge pulses, measures
// each half-period and tracks lock/loss against the expected divider setting.
module clk_edge_monitor #(
    parameter int CW       = 26,
    parameter int EXP_HALF = 12500001,
    parameter int TOL      = 1000,
    parameter int LOCK_N   = 4
) (
    input  logic            clk_in,
    input  logic            rst,
    clk_edge_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_t;

    localparam int              GW        = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]   HI        = CW'(EXP_HALF + TOL);
    localparam logic [CW-1:0]   LO        = CW'(EXP_HALF - TOL);
    localparam logic [GW-1:0]   GOOD_LOCK = GW'(LOCK_N);

    logic          s1, s2, s3;
    logic          rise_q, fall_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] meas;
    logic          ev, timeout;
    logic [GW-1:0] good, good_n, good_inc;
    state_t        state, state_n;
    logic          hv_n;
    logic [CW-1:0] hc_n;
    logic [CW-1:0] half_cnt_q;
    logic          half_valid_q, locked_q, lost_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    function automatic logic in_tol(input logic [CW-1:0] m);
        return (m >= LO) && (m <= HI);
    endfunction

    assign ev       = s2 ^ s3;
    assign meas     = sat_inc(cnt);
    assign timeout  = (cnt == HI) && !ev;
    assign good_inc = good + GW'(1);

    // Synchroniser, edge pulses and free-running half-period counter
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= mon.sig_in;
            s2     <= s1;
            s3     <= s2;
            rise_q <= s2 & ~s3;
            fall_q <= ~s2 & s3;
            cnt    <= ev ? '0 : sat_inc(cnt);
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good;
        hv_n    = 1'b0;
        hc_n    = half_cnt_q;
        case (state)
            IDLE: begin
                if (ev) begin
                    state_n = ACQ;
                    good_n  = '0;
                end
            end
            ACQ: begin
                if (ev) begin
                    hv_n = 1'b1;
                    hc_n = meas;
                    if (in_tol(meas)) begin
                        good_n = good_inc;
                        if (good_inc == GOOD_LOCK)
                            state_n = LOCKED;
                    end else begin
                        good_n = '0;
                    end
                end else if (timeout) begin
                    state_n = LOST;
                end
            end
            LOCKED: begin
                if (ev) begin
                    hv_n = 1'b1;
                    hc_n = meas;
                    if (!in_tol(meas)) begin
                        state_n = ACQ;
                        good_n  = '0;
                    end
                end else if (timeout) begin
                    state_n = LOST;
                end
            end
            LOST: begin
                // Interval since the last toggle is meaningless, so no strobe here
                if (ev) begin
                    state_n = ACQ;
                    good_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            good         <= '0;
            half_valid_q <= 1'b0;
            half_cnt_q   <= '0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state        <= state_n;
            good         <= good_n;
            half_valid_q <= hv_n;
            half_cnt_q   <= hc_n;
            locked_q     <= (state_n == LOCKED);
            lost_q       <= (state_n == LOST);
        end
    end

    assign mon.rise_pulse = rise_q;
    assign mon.fall_pulse = fall_q;
    assign mon.half_cnt   = half_cnt_q;
    assign mon.half_valid = half_valid_q;
    assign mon.locked     = locked_q;
    assign mon.lost       = lost_q;
endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor with CW=8, EXP_HALF=10, TOL=1, LOCK_N=2.
module tb_clk_edge_monitor;
    logic clk;
    logic rst;
    int   vec;
    int   errs;
    int   rise_seen;
    int   hv_seen;

    clk_edge_monitor_if #(.CW(8)) mon ();

    clk_edge_monitor #(
        .CW(8), .EXP_HALF(10), .TOL(1), .LOCK_N(2)
    ) dut (
        .clk_in(clk),
        .rst   (rst),
        .mon   (mon)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulses"}, {30'd0, mon.rise_pulse, mon.fall_pulse}, 32'd0);
        chk({tag, "_hv"}, {31'd0, mon.half_valid}, 32'd0);
        chk({tag, "_hc"}, {24'd0, mon.half_cnt}, 32'd0);
        chk({tag, "_status"}, {30'd0, mon.locked, mon.lost}, 32'd0);
    endtask

    // Cursor sits just after the edge where the previous event acted; the next
    // toggle is placed so the new event acts exactly gap edges later (gap >= 4).
    task automatic do_event(input string tag, input int gap, input bit hv,
                            input int hc, input bit lk, input bit ls);
        tick();
        chk({tag, "_quiet"}, {29'd0, mon.rise_pulse, mon.fall_pulse, mon.half_valid}, 32'd0);
        repeat (gap - 4) tick();
        @(negedge clk);
        mon.sig_in = ~mon.sig_in;
        tick();
        tick();
        chk({tag, "_early"}, {30'd0, mon.rise_pulse, mon.fall_pulse}, 32'd0);
        tick();
        chk({tag, "_edge"}, {30'd0, mon.rise_pulse, mon.fall_pulse},
            {30'd0, mon.sig_in, ~mon.sig_in});
        chk({tag, "_hv"}, {31'd0, mon.half_valid}, {31'd0, hv});
        chk({tag, "_hc"}, {24'd0, mon.half_cnt}, hc);
        chk({tag, "_locked"}, {31'd0, mon.locked}, {31'd0, lk});
        chk({tag, "_lost"}, {31'd0, mon.lost}, {31'd0, ls});
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        rst  = 1'b1;
        mon.sig_in = 1'b0;
        tick();
        chk_all_zero("in_reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all_zero("after_release");

        // Steady toggling every 10 cycles: lock after the third event
        do_event("e1", 5, 1'b0, 0, 1'b0, 1'b0);
        do_event("e2", 10, 1'b1, 10, 1'b0, 1'b0);
        do_event("e3", 10, 1'b1, 10, 1'b1, 1'b0);
        do_event("e4", 10, 1'b1, 10, 1'b1, 1'b0);

        // Long interval drops lock, two short ones regain it
        do_event("e5", 12, 1'b1, 12, 1'b0, 1'b0);
        do_event("e6", 9, 1'b1, 9, 1'b0, 1'b0);
        do_event("e7", 9, 1'b1, 9, 1'b1, 1'b0);

        // Toggling stops: lost one cycle after cnt reaches 11
        repeat (11) tick();
        chk("pre_timeout", {30'd0, mon.locked, mon.lost}, 32'd2);
        tick();
        chk("timeout", {30'd0, mon.locked, mon.lost}, 32'd1);
        repeat (3) tick();
        chk("lost_hold_hc", {24'd0, mon.half_cnt}, 32'd9);
        do_event("e8", 5, 1'b0, 9, 1'b0, 1'b0);
        do_event("e9", 10, 1'b1, 10, 1'b0, 1'b0);

        // Toggle exactly at cnt==11 beats timeout; tolerance edges 11 and 9
        do_event("e10", 12, 1'b1, 12, 1'b0, 1'b0);
        do_event("e11", 11, 1'b1, 11, 1'b0, 1'b0);
        do_event("e12", 9, 1'b1, 9, 1'b1, 1'b0);

        // Asynchronous reset mid-count while locked
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        mon.sig_in = 1'b1;
        tick();
        tick();
        chk_all_zero("rst_held");

        // sig_in high through release: exactly one rise pulse, no strobe
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("hi_rel_e1", {31'd0, mon.rise_pulse}, 32'd0);
        tick();
        chk("hi_rel_e2", {31'd0, mon.rise_pulse}, 32'd0);
        tick();
        chk("hi_rel_rise", {31'd0, mon.rise_pulse}, 32'd1);
        chk("hi_rel_hv", {31'd0, mon.half_valid}, 32'd0);
        chk("hi_rel_hc", {24'd0, mon.half_cnt}, 32'd0);
        rise_seen = 0;
        hv_seen   = 0;
        repeat (6) begin
            tick();
            rise_seen += int'(mon.rise_pulse);
            hv_seen   += int'(mon.half_valid);
        end
        chk("hi_rel_single_rise", rise_seen, 32'd0);
        chk("hi_rel_no_hv", hv_seen, 32'd0);

        // Long silence past counter range, then resume toggling
        hv_seen = 0;
        repeat (300) begin
            tick();
            hv_seen += int'(mon.half_valid);
        end
        chk("long_silence_hv", hv_seen, 32'd0);
        chk("long_silence_status", {30'd0, mon.locked, mon.lost}, 32'd1);
        do_event("e13", 5, 1'b0, 0, 1'b0, 1'b0);
        do_event("e14", 10, 1'b1, 10, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
